// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encoding, bus target IDs and ack field layout.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } arb_state_e;

  localparam logic [1:0] MEM_ID = 2'b00;
  localparam logic [1:0] SHA_ID = 2'b01;
  localparam logic [1:0] AES_ID = 2'b10;

  localparam int ACK_VALID_BIT = 2;
  localparam int DEF_ADDRW     = 24;
  localparam int CMDW          = DEF_ADDRW + 8;

  function automatic int cmd_width(input int addrw);
    return addrw + 8;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last+1, wrapping.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic            found,
  output logic [LW-1:0]   idx
);

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last) + k) % NREQ;
      if (!found && req[LW'(j)]) begin
        found = 1'b1;
        idx   = LW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared command bus; holds ownership until the target acks.
// Optional HOLD watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDRW   = 24,
  parameter int TIMEOUT = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NREQ-1:0]                   arb_req,
  output logic [NREQ-1:0]                   arb_grant,
  input  logic [NREQ*cmd_width(ADDRW)-1:0]  req_data,
  input  logic [2:0]                        ack_in,
  output logic [cmd_width(ADDRW)-1:0]       bus_data_out,
  output logic                              bus_valid_out,
  output logic                              bus_busy,
  output logic [$clog2(NREQ)-1:0]           bus_owner,
  output logic                              timeout_err
);

  localparam int LW = $clog2(NREQ);
  localparam int CW = cmd_width(ADDRW);

  arb_state_e      state_q;
  logic [LW-1:0]   owner_q, last_q;
  logic [NREQ-1:0] grant_q;
  logic            valid_q, busy_q, tout_q;
  logic            pick_found;
  logic [LW-1:0]   pick_idx;
  logic            ack_vld;
  logic            unused_ack_src;

  assign ack_vld        = ack_in[ACK_VALID_BIT];
  assign unused_ack_src = ^ack_in[1:0];

  rr_pick #(.NREQ(NREQ), .LW(LW)) u_pick (
    .req   (arb_req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= LW'(NREQ - 1);
      grant_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      grant_q <= '0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            owner_q <= pick_idx;
            grant_q <= NREQ'(1) << pick_idx;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          state_q <= ST_HOLD;
`ifdef ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        ST_HOLD: begin
          // An ack always beats a coincident timeout.
          if (ack_vld) begin
            last_q  <= owner_q;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt_q + 1'b1 == TW'(TIMEOUT)) begin
            tout_q  <= 1'b1;
            last_q  <= owner_q;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign arb_grant     = grant_q;
  assign bus_valid_out = valid_q;
  assign bus_busy      = busy_q;
  assign bus_owner     = owner_q;
  assign bus_data_out  = busy_q ? req_data[owner_q*CW +: CW] : '0;
`ifdef ARB_TIMEOUT_EN
  assign timeout_err   = tout_q;
`else
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (NREQ=2, ADDRW=24, TIMEOUT=16).
module tb_bus_arbiter;

  localparam int NREQ = 2;
  localparam int CW   = 32;
  localparam logic [CW-1:0] D0 = 32'hA0C0_1234;
  localparam logic [CW-1:0] D1 = 32'h5B00_ABCD;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] arb_req = '0;
  logic [NREQ-1:0] arb_grant;
  logic [NREQ*CW-1:0] req_data = {D1, D0};
  logic [2:0]      ack_in = 3'b000;
  logic [CW-1:0]   bus_data_out;
  logic            bus_valid_out, bus_busy, timeout_err;
  logic [0:0]      bus_owner;

  int vectors = 0;
  int miscompares = 0;

  bus_arbiter #(.NREQ(NREQ), .ADDRW(24), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .arb_req       (arb_req),
    .arb_grant     (arb_grant),
    .req_data      (req_data),
    .ack_in        (ack_in),
    .bus_data_out  (bus_data_out),
    .bus_valid_out (bus_valid_out),
    .bus_busy      (bus_busy),
    .bus_owner     (bus_owner),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    arb_req = '0;
    ack_in  = 3'b000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, 32'(arb_grant), 32'h0);
    chk({tag, "_valid"}, 32'(bus_valid_out), 32'h0);
    chk({tag, "_busy"},  32'(bus_busy), 32'h0);
    chk({tag, "_data"},  bus_data_out, 32'h0);
    chk({tag, "_terr"},  32'(timeout_err), 32'h0);
  endtask

  initial begin
    // Reset state
    tick();
    chk_idle("rst");
    chk("rst_owner", 32'(bus_owner), 32'h0);
    rst = 1'b0;

    // 1: single requester FSM 0
    arb_req = 2'b01;
    tick();
    chk("t1_grant", 32'(arb_grant), 32'h1);
    chk("t1_valid", 32'(bus_valid_out), 32'h1);
    chk("t1_data",  bus_data_out, D0);
    chk("t1_busy",  32'(bus_busy), 32'h1);
    arb_req = 2'b00;
    tick();
    chk("t1_hold_grant", 32'(arb_grant), 32'h0);
    chk("t1_hold_valid", 32'(bus_valid_out), 32'h0);
    chk("t1_hold_data",  bus_data_out, D0);
    chk("t1_hold_busy",  32'(bus_busy), 32'h1);
    ack_in = 3'b100;
    tick();
    ack_in = 3'b000;
    chk_idle("t1_rel");
    chk("t1_owner", 32'(bus_owner), 32'h0);

    // 2: both request right after reset -> 0 first, 1 two cycles after ack
    do_reset();
    arb_req = 2'b11;
    tick();
    chk("t2_g0", 32'(arb_grant), 32'h1);
    tick();
    ack_in = 3'b100;
    tick();
    ack_in = 3'b000;
    chk("t2_idle_grant", 32'(arb_grant), 32'h0);
    chk("t2_idle_busy",  32'(bus_busy), 32'h0);
    tick();
    chk("t2_g1",    32'(arb_grant), 32'h2);
    chk("t2_owner", 32'(bus_owner), 32'h1);
    chk("t2_data",  bus_data_out, D1);

    // 3: saturated requests alternate 0,1,0,1,0,1
    do_reset();
    arb_req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t3_grant%0d", k), 32'(arb_grant), (k % 2) ? 32'h2 : 32'h1);
      chk($sformatf("t3_onehot%0d", k), 32'($onehot(arb_grant)), 32'h1);
      tick();
      chk($sformatf("t3_hold%0d", k), 32'(arb_grant), 32'h0);
      ack_in = 3'b100;
      tick();
      ack_in = 3'b000;
      chk($sformatf("t3_idle%0d", k), 32'(arb_grant), 32'h0);
    end
    arb_req = 2'b00;

    // 4: ack during GRANT ignored; invalid acks keep HOLD
    do_reset();
    arb_req = 2'b01;
    tick();
    arb_req = 2'b00;
    ack_in  = 3'b100;
    tick();
    chk("t4_grant_ack_ignored", 32'(bus_busy), 32'h1);
    for (int i = 0; i < 10; i++) begin
      ack_in = (i % 2) ? 3'b010 : 3'b001;
      tick();
      chk($sformatf("t4_busy%0d", i), 32'(bus_busy), 32'h1);
      chk($sformatf("t4_data%0d", i), bus_data_out, D0);
    end
    chk("t4_valid", 32'(bus_valid_out), 32'h0);
    ack_in = 3'b101;
    tick();
    ack_in = 3'b000;
    chk("t4_rel_busy", 32'(bus_busy), 32'h0);

    // 5: async reset during HOLD
    do_reset();
    arb_req = 2'b10;
    tick();
    arb_req = 2'b00;
    tick();
    chk("t5_pre_owner", 32'(bus_owner), 32'h1);
    rst = 1'b1;
    #1;
    chk_idle("t5_rst");
    chk("t5_rst_owner", 32'(bus_owner), 32'h0);
    arb_req = 2'b11;
    tick();
    rst = 1'b0;
    tick();
    chk("t5_g0", 32'(arb_grant), 32'h1);
    tick();
    ack_in = 3'b100;
    tick();
    ack_in = 3'b000;

`ifdef ARB_TIMEOUT_EN
    // 6: HOLD watchdog, 16 HOLD cycles
    do_reset();
    arb_req = 2'b11;
    tick();
    chk("t6_g0", 32'(arb_grant), 32'h1);
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("t6_wait%0d", i), 32'({bus_busy, timeout_err}), 32'h2);
    end
    tick();
    chk("t6_terr",      32'(timeout_err), 32'h1);
    chk("t6_terr_busy", 32'(bus_busy), 32'h0);
    tick();
    chk("t6_terr_pulse", 32'(timeout_err), 32'h0);
    chk("t6_g1",         32'(arb_grant), 32'h2);
    tick();
    for (int i = 0; i < 15; i++) tick();
    ack_in = 3'b100;
    tick();
    ack_in = 3'b000;
    chk("t6_ack_wins_terr", 32'(timeout_err), 32'h0);
    chk("t6_ack_wins_busy", 32'(bus_busy), 32'h0);
    tick();
    chk("t6_g0_again", 32'(arb_grant), 32'h1);
`else
    // 6: no watchdog -> HOLD persists past TIMEOUT cycles
    do_reset();
    arb_req = 2'b01;
    tick();
    arb_req = 2'b00;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk($sformatf("t6_hold%0d", i), 32'({bus_busy, timeout_err}), 32'h2);
    end
    ack_in = 3'b100;
    tick();
    ack_in = 3'b000;
    chk("t6_rel", 32'(bus_busy), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
